// File: rtl/attn_out_proj.sv
// Attention output projection: requantizes one HEADS-wide attention vector to DW bits,
// then streams the D outputs of y = W_o * q using a single time-multiplexed MAC.
module attn_out_proj #(
  parameter int HEADS   = 12,
  parameter int D       = 64,
  parameter int DW      = 4,
  parameter int FRAC_W  = 4,
  parameter int SEQ_LEN = 2048,
  localparam int IW     = DW + FRAC_W + $clog2(SEQ_LEN),
  localparam int ACC_W  = 2 * DW + $clog2(HEADS),
  localparam int IDX_W  = $clog2(D)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IW-1:0]    in_vec [HEADS],
  input  logic signed [DW-1:0]    wo [D*HEADS],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy
);

  localparam int HW     = (HEADS > 1) ? $clog2(HEADS) : 1;
  localparam int WIDX_W = $clog2(D * HEADS);

  localparam logic signed [IW:0] RND  = (IW+1)'(2 ** (FRAC_W - 1));
  localparam logic signed [IW:0] QMAX = (IW+1)'(2 ** (DW - 1) - 1);
  localparam logic signed [IW:0] QMIN = (IW+1)'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {IDLE, QUANT, MAC, EMIT} state_t;

  state_t                  state;
  logic signed [IW-1:0]    vec_r [HEADS];
  logic signed [DW-1:0]    q     [HEADS];
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        d_cnt;
  logic [HW-1:0]           h_cnt;

  logic signed [DW-1:0]    q_sel;
  logic signed [DW-1:0]    w_sel;
  logic [WIDX_W-1:0]       w_idx;
  logic [ACC_W-1:0]        prod;
  logic signed [ACC_W-1:0] acc_next;

  // Round half toward +inf, arithmetic shift, then clamp to the signed DW range.
  // The add is one bit wider than the input so the rounding offset cannot wrap.
  function automatic logic signed [DW-1:0] requant(input logic signed [IW-1:0] x);
    logic signed [IW:0] t;
    t = (IW+1)'(x) + RND;
    t = t >>> FRAC_W;
    if (t > QMAX)      requant = QMAX[DW-1:0];
    else if (t < QMIN) requant = QMIN[DW-1:0];
    else               requant = t[DW-1:0];
  endfunction

  // NOTE: in_ready and busy are pure decodes of the registered state; a full
  // default-free assign cannot infer a latch and adds no extra cycle of latency.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    q_sel    = q[h_cnt];
    w_idx    = WIDX_W'(d_cnt) * WIDX_W'(HEADS) + WIDX_W'(h_cnt);
    w_sel    = wo[w_idx];
    // Sign-extend both factors to the accumulator width; the low ACC_W bits of
    // the product are the correct two's complement result.
    prod     = {{(ACC_W-DW){q_sel[DW-1]}}, q_sel} * {{(ACC_W-DW){w_sel[DW-1]}}, w_sel};
    acc_next = acc + $signed(prod);
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      d_cnt     <= '0;
      h_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      // NOTE: these arrays are small flop-based register files, not RAM, so an
      // async clear is legal and leaves no stale q behind an abandoned vector.
      for (int h = 0; h < HEADS; h++) begin
        vec_r[h] <= '0;
        q[h]     <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int h = 0; h < HEADS; h++) vec_r[h] <= in_vec[h];
            d_cnt <= '0;
            state <= QUANT;
          end
        end
        QUANT: begin
          for (int h = 0; h < HEADS; h++) q[h] <= requant(vec_r[h]);
          acc   <= '0;
          h_cnt <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_next;
          if (h_cnt == HW'(HEADS - 1)) begin
            h_cnt     <= '0;
            out_data  <= acc_next;
            out_idx   <= d_cnt;
            out_last  <= (d_cnt == IDX_W'(D - 1));
            out_valid <= 1'b1;
            state     <= EMIT;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (d_cnt == IDX_W'(D - 1)) begin
              state <= IDLE;
            end else begin
              d_cnt <= d_cnt + 1'b1;
              acc   <= '0;
              h_cnt <= '0;
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/attn_out_proj.md
Name: attn_out_proj

Overview:
- Downstream stage of the attention top level. Consumes one per-head attention result vector of HEADS wide fixed-point values.
- Requantizes each value back to DW bits, then applies the output projection W_o (D x HEADS) using a single time-multiplexed MAC.
- Streams D projected results out over a valid/ready interface, one per beat, toward the residual/FFN path.

Parameters:
- HEADS, 12, number of input elements per vector (attention heads)
- D, 64, number of projected output elements
- DW, 4, weight and requantized data bitwidth (signed)
- FRAC_W, 4, fractional bits of the input; also the requant right-shift amount (must be >= 1)
- SEQ_LEN, 2048, sequence length; sets input width
- IW, DW+FRAC_W+$clog2(SEQ_LEN) (=19), input element width (signed)
- ACC_W, 2*DW+$clog2(HEADS) (=12), accumulator and output width (signed)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_vec  in  HEADS x IW signed  attention output vector, element h = head h
- wo  in  D*HEADS x DW signed  projection weights, static, row-major; element (d,h) at index d*HEADS+h
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts beat
- out_data  out  ACC_W signed  projected element y[d]
- out_idx  out  $clog2(D)  index d of current beat
- out_last  out  1  high on beat d = D-1
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, takes effect asynchronously):
  - state = IDLE; in_ready = 1; out_valid = 0; out_data = 0; out_idx = 0; out_last = 0; busy = 0.
  - Internal q registers, accumulator, and the d/h counters clear to 0.
  - Reset mid-operation abandons the vector; no partial beats follow.
- States: IDLE, QUANT, MAC, EMIT.
- IDLE:
  - in_ready = 1 (combinational on state). All other states drive in_ready = 0; in_valid is ignored there.
  - On an edge with in_valid && in_ready: latch in_vec, d <= 0, go to QUANT.
- QUANT (1 cycle):
  - For each h: q[h] = sat_DW((in_vec[h] + 2^(FRAC_W-1)) >>> FRAC_W).
  - The add is done at IW+1 bits. Arithmetic shift; rounding is half toward +inf.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1], i.e. [-8, 7].
  - acc <= 0, h <= 0, go to MAC.
- MAC (HEADS cycles):
  - Each edge: acc <= acc + q[h]*wo[d*HEADS+h]; h increments.
  - On the edge with h == HEADS-1: go to EMIT. out_data <= final sum (including that term); out_idx <= d; out_last <= (d == D-1); out_valid <= 1.
- EMIT:
  - out_valid, out_data, out_idx and out_last are held stable until out_valid && out_ready.
  - On the transfer edge, out_valid <= 0.
    - If d == D-1: go to IDLE.
    - Else: d <= d+1, acc <= 0, h <= 0, go to MAC.
- Width: |q*w| <= 64; 64*12 = 768 < 2^(ACC_W-1). The accumulator never overflows, so no output saturation is applied.
- Latency, with the acceptance edge = edge 0:
  - out_valid first visible after edge HEADS+1 (cycle 14 for defaults).
  - With out_ready held high, beats are every HEADS+1 cycles.
  - in_ready returns 1 the cycle after the last transfer edge.
- All outputs are registered, except in_ready and busy, which decode directly from state.

Test Plan:
- Reset: hold rst=0, then release with no stimulus -> in_ready=1; out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. Assert rst=0 asynchronously mid-cycle -> the same values appear before the next clk edge.
- Basic: all in_vec=16 (1.0), all wo=1, out_ready=1 -> 64 beats each out_data=12, out_idx 0..63. out_last only at idx 63. First out_valid 14 cycles after acceptance, beats 13 cycles apart.
- Round/saturate:
  - Stimulus: in_vec[0..5] = 8, 7, -8, -9, 1000, -1000; rest 0; all wo=1.
  - Required q values: 1, 0, 0, -1, 7, -8.
  - Required output: every beat out_data = -1.
- Extremes: all in_vec=-128 (q=-8), all wo=-8 -> every out_data=768. Then wo row d=3 set to +7 -> beat 3 = -672, others 768.
- Backpressure:
  - Stimulus: drop out_ready for 10 cycles while beat 5 is valid; pulse in_valid during busy.
  - Required: out_valid stays 1; out_data/out_idx stay stable; beat 5 is delivered once; no beats are lost or duplicated; in_ready stays 0; the second vector is not consumed until IDLE.
- Reset mid-MAC: assert rst during beat 20 accumulation -> outputs clear immediately. After release, a new vector (in_vec=32, wo=1) yields out_data=24 for all 64 beats.
